instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter AW, default 10: instruction-memory word-address width; memory depth 2^AW words.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse: clear address, count, FIFO and err; begin loading.
REQ-005 in_valid  input  1  instruction fields valid.
REQ-006 in_ready  output  1  block can accept fields this cycle.
REQ-007 op_sel  input  4  0 addi, 1 lw, 2 sw, 3 beq, 4 bne, 5 bgtz, 6 add, 7 addu, 8 sub, 9 subu, 10 and, 11 or, 12 sll, 13 slt, 14 sltu, 15 illegal.
REQ-008 rs, rt, rd, shamt  input  5 each  register and shift-amount fields.
REQ-009 imm  input  16  immediate / branch offset.
REQ-010 imem_we  output  1  write request, data and address valid.
REQ-011 imem_ready  input  1  memory accepts write this cycle.
REQ-012 imem_addr  output  AW  word address of current write.
REQ-013 imem_wdata  output  32  encoded instruction word.
REQ-014 count  output  AW+1  number of words written since last start.
REQ-015 full  output  1  memory filled, no more input accepted.
REQ-016 err  output  1  sticky: illegal op_sel presented.

Function
REQ-017 Encoding SHALL be the exact inverse of the pipeline's control decoder: opcodes addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111, R-type 000000.
REQ-018 R-type funct: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, sll 000000, slt 101010, sltu 101011.
REQ-019 R-type word = opc[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]; sll forces rs=0; all other R-type force shamt=0.
REQ-020 I-type word = opc rs rt imm[15:0]; bgtz forces rt=0; rd and shamt ignored.
REQ-021 States: IDLE, LOAD, FULL, ERR; reset enters IDLE.
REQ-022 start SHALL move any state to LOAD next cycle and take priority over every other event in that cycle (input in that cycle not accepted, no address increment).
REQ-023 in_ready = 1 only in LOAD with fewer than 2 entries in the output FIFO.
REQ-024 Accept = in_valid & in_ready; legal op encoded combinationally and pushed into 2-entry FIFO on that edge.
REQ-025 Latency: word accepted at edge N SHALL appear on imem_wdata with imem_we=1 in cycle N+1 when FIFO was empty.
REQ-026 imem_we = FIFO non-empty; imem_wdata/imem_addr held stable while imem_we=1 and imem_ready=0.
REQ-027 Write completes on imem_we & imem_ready: pop FIFO, imem_addr += 1, count += 1.
REQ-028 Push and pop in same cycle SHALL keep FIFO occupancy unchanged; order preserved.
REQ-029 Accepted op_sel=15: no push, err=1, state ERR; in_ready=0; FIFO entries already queued still drain.
REQ-030 Outstanding accepts SHALL be limited so accepts never exceed 2^AW words; when count reaches 2^AW, state FULL, full=1, imem_addr wraps to 0 and is not used.
REQ-031 In FULL and ERR no input accepted until start.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, FIFO empty, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, count 0, full 0, err 0.
REQ-033 rst_n low mid-write SHALL discard queued words; no write completes after reset asserts.

Verification
REQ-034 start, then add rs=1 rt=2 rd=3 shamt=7 -> cycle later imem_wdata=0x00221820, imem_addr=0, count=1 after write.
REQ-035 lw rs=4 rt=5 imm=0xFFFC then bgtz rs=6 rt=9 imm=0x0003 -> 0x8C85FFFC at addr 0, 0x1CC00003 at addr 1.
REQ-036 imem_ready=0 with continuous in_valid -> exactly 2 accepts, then in_ready=0, data held; release -> both written in order.
REQ-037 op_sel=15 after one legal word -> legal word written, err=1, in_ready=0; start -> err=0, count=0, LOAD.
REQ-038 AW=2, 5 back-to-back legal words -> 4 written at addr 0..3, full=1, fifth never accepted.
REQ-039 rst_n pulsed low while FIFO holds 2 words -> all outputs at reset values immediately, imem_we=0.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - instruction field encoder with 2-entry write FIFO into instruction memory
module instr_encoder #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [15:0]   imm,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_ERR} state_t;

  state_t        r_state;
  logic [31:0]   r_mem [2];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_occ;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_acc;     // words accepted since start; caps outstanding work at memory depth
  logic          r_full;
  logic          r_err;

  logic [31:0]   w_word;
  logic          w_legal;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  // Encode the presented fields into a machine word; op_sel 15 is the only illegal code
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (op_sel)
      4'd0:    w_word = {6'b001000, rs, rt, imm};
      4'd1:    w_word = {6'b100011, rs, rt, imm};
      4'd2:    w_word = {6'b101011, rs, rt, imm};
      4'd3:    w_word = {6'b000100, rs, rt, imm};
      4'd4:    w_word = {6'b000101, rs, rt, imm};
      4'd5:    w_word = {6'b000111, rs, 5'd0, imm};
      4'd6:    w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      4'd7:    w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
      4'd8:    w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      4'd9:    w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
      4'd10:   w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
      4'd11:   w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
      4'd12:   w_word = {6'b000000, 5'd0, rt, rd, shamt, 6'b000000};
      4'd13:   w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
      4'd14:   w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b101011};
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready   = (r_state == S_LOAD) && !r_occ[1] && (r_acc < DEPTH);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && w_legal;
  assign imem_we    = (r_occ != 2'd0);
  assign w_pop      = imem_we && imem_ready;
  assign imem_wdata = r_mem[r_rd];
  assign imem_addr  = r_addr;
  assign count      = r_count;
  assign full       = r_full;
  assign err        = r_err;

  // Control FSM plus FIFO and write-address bookkeeping; start overrides any same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_occ    <= 2'd0;
      r_addr   <= '0;
      r_count  <= '0;
      r_acc    <= '0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else if (start) begin
      r_state <= S_LOAD;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_occ   <= 2'd0;
      r_addr  <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_word;
        r_wr        <= ~r_wr;
        r_acc       <= r_acc + 1'b1;
      end
      if (w_pop) begin
        r_rd    <= ~r_rd;
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      // Queued words still drain after an illegal op; only new input is refused
      if (w_accept && !w_legal) begin
        r_state <= S_ERR;
        r_err   <= 1'b1;
      end else if (r_state == S_LOAD && w_pop && r_count == DEPTH - 1'b1) begin
        r_state <= S_FULL;
        r_full  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with reference encoder model
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op_sel = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0]   imm = '0;
  logic          imem_we;
  logic          imem_ready = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encoder #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          addr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_acc = 0;
  bit   exp_err = 1'b0;
  bit   exp_active = 1'b0;
  bit   fixed_ready = 1'b1;
  bit   rand_ready = 1'b0;

  int opc_tab [6] = '{8, 35, 43, 4, 5, 7};
  int fn_tab  [9] = '{32, 33, 34, 35, 36, 37, 0, 42, 43};

  // Reference: assemble the word from opcode/funct tables and field positions
  function automatic logic [31:0] ref_encode(int op, int f_rs, int f_rt, int f_rd, int f_sh, int f_imm);
    logic [31:0] w;
    if (op < 6)
      w = (32'(opc_tab[op]) << 26) | (32'(f_rs) << 21) | (32'((op == 5) ? 0 : f_rt) << 16) | 32'(f_imm);
    else
      w = (32'((op == 12) ? 0 : f_rs) << 21) | (32'(f_rt) << 16) | (32'(f_rd) << 11)
        | (32'((op == 12) ? f_sh : 0) << 6) | 32'(fn_tab[op - 6]);
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory-side ready: fixed level or random backpressure
  always @(posedge clk) begin
    #1;
    imem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  // Monitor: compare every completed write against the scoreboard, and check stall stability
  logic [31:0]   hold_w;
  logic [AW-1:0] hold_a;
  bit            hold_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && imem_we) begin
        check("hold_wdata", imem_wdata, hold_w);
        check("hold_addr", 32'(imem_addr), 32'(hold_a));
      end
      if (imem_we && imem_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(imem_we), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wdata", imem_wdata, e.word);
          check("waddr", 32'(imem_addr), 32'(e.addr));
        end
        hold_valid = 1'b0;
      end else if (imem_we) begin
        hold_valid = 1'b1;
        hold_w = imem_wdata;
        hold_a = imem_addr;
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  task automatic do_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_acc = 0;
    exp_err = 1'b0;
    exp_active = 1'b1;
  endtask

  task automatic send(input int op, input int a, input int b, input int c, input int d, input int im);
    bit done;
    done = 1'b0;
    op_sel = 4'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(d); imm = 16'(im);
    in_valid = 1'b1;
    if (!exp_active || exp_err || exp_acc >= DEPTH) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("reject_in_ready", 32'(in_ready), 32'd0);
      end
    end else begin
      for (int i = 0; i < 60 && !done; i++) begin
        @(negedge clk);
        if (in_ready) done = 1'b1;
      end
      if (!done) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
      end else if (op == 15) begin
        exp_err = 1'b1;
      end else begin
        sb.push_back('{word: ref_encode(op, a, b, c, d, im), addr: exp_acc % DEPTH});
        exp_acc++;
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic end_episode();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !imem_we) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(sb.size()), 32'd0);
    check("count", 32'(count), 32'(exp_acc));
    check("full", 32'(full), 32'(exp_acc == DEPTH));
    check("err", 32'(err), 32'(exp_err));
    check("end_addr", 32'(imem_addr), 32'(exp_acc % DEPTH));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Single add, one-cycle latency
    do_start();
    check("load_in_ready", 32'(in_ready), 32'd1);
    send(6, 1, 2, 3, 7, 0);
    check("lat_we", 32'(imem_we), 32'd1);
    check("lat_wdata", imem_wdata, 32'h00221820);
    check("lat_addr", 32'(imem_addr), 32'd0);
    end_episode();

    // lw then bgtz with rt forced to zero
    do_start();
    send(1, 4, 5, 0, 0, 16'hFFFC);
    send(5, 6, 9, 0, 0, 16'h0003);
    end_episode();

    // Backpressure: two accepts then in_ready drops while data is held
    do_start();
    fixed_ready = 1'b0;
    step();
    step();
    send(8, 3, 4, 5, 9, 0);
    send(11, 7, 8, 9, 2, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_we", 32'(imem_we), 32'd1);
    end
    in_valid = 1'b0;
    fixed_ready = 1'b1;
    send(13, 1, 1, 1, 1, 0);
    end_episode();

    // Illegal op after one legal word, then recovery via start
    do_start();
    send(0, 2, 3, 0, 0, 16'h1234);
    send(15, 0, 0, 0, 0, 0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_in_ready", 32'(in_ready), 32'd0);
    end_episode();
    do_start();
    check("restart_err", 32'(err), 32'd0);
    check("restart_count", 32'(count), 32'd0);
    check("restart_in_ready", 32'(in_ready), 32'd1);

    // Fill memory: fifth word refused, full set, address wrapped
    for (int i = 0; i < 5; i++)
      send(12, 31, i + 1, i + 2, i + 3, 0);
    end_episode();

    // Asynchronous reset with two queued words
    do_start();
    fixed_ready = 1'b0;
    step();
    step();
    send(7, 1, 2, 3, 0, 0);
    send(9, 4, 5, 6, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_we", 32'(imem_we), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd0);
    check("ar_addr", 32'(imem_addr), 32'd0);
    check("ar_wdata", imem_wdata, 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_full", 32'(full), 32'd0);
    check("ar_err", 32'(err), 32'd0);
    sb.delete();
    exp_active = 1'b0;
    exp_acc = 0;
    exp_err = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    fixed_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd0);
    check("post_rst_we", 32'(imem_we), 32'd0);

    // Randomized episodes with random backpressure
    rand_ready = 1'b1;
    repeat (25) begin
      int n;
      do_start();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        int op;
        op = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 14);
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535));
      end
      end_episode();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
